// File: rtl/sub_32_bit_seq.sv
// Multi-cycle subtractor: answer = input1 - input2, one CHUNK-bit slice per cycle, LSB first.
// Optional signed flags (zero/negative/overflow) are built only when SUB_FLAGS_EN is defined.
module sub_32_bit_seq #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] answer,
    output logic         borrow_out,
    output logic         zero,
    output logic         negative,
    output logic         overflow
);

    localparam int K  = N / CHUNK;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b_inv;
    logic             carry;
    logic [KW-1:0]    k;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;
    logic             last;

    assign a_chunk = op_a[k*CHUNK +: CHUNK];
    assign b_chunk = op_b_inv[k*CHUNK +: CHUNK];
    assign sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry);
    assign last    = (k == KW'(K - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            answer     <= '0;
            borrow_out <= 1'b0;
            op_a       <= '0;
            op_b_inv   <= '0;
            carry      <= 1'b0;
            k          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a     <= input1;
                        op_b_inv <= ~input2;
                        carry    <= 1'b1;   // the +1 of two's complement
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    answer[k*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
                    carry                    <= sum[CHUNK];
                    if (last) begin
                        borrow_out <= ~sum[CHUNK];
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SUB_FLAGS_EN
    logic [N-1:0] answer_next;

    always_comb begin
        answer_next                   = answer;
        answer_next[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    end

    // op_b_inv holds ~input2, so differing operand signs show up as equal stored MSBs.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (state == BUSY && last) begin
            zero     <= (answer_next == '0);
            negative <= answer_next[N-1];
            overflow <= (op_a[N-1] == op_b_inv[N-1]) && (answer_next[N-1] != op_a[N-1]);
        end
    end
`else
    assign zero     = 1'b0;
    assign negative = 1'b0;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sub_32_bit_seq.sv
// Self-checking bench for sub_32_bit_seq: directed corner cases plus random operands
// against an arithmetic reference model; flag expectations follow SUB_FLAGS_EN.
module tb_sub_32_bit_seq;

    localparam int N     = 32;
    localparam int CHUNK = 8;
    localparam int K     = N / CHUNK;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] input1;
    logic [N-1:0] input2;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] answer;
    logic         borrow_out;
    logic         zero;
    logic         negative;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    sub_32_bit_seq #(.N(N), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .input1     (input1),
        .input2     (input2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .answer     (answer),
        .borrow_out (borrow_out),
        .zero       (zero),
        .negative   (negative),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain modular / signed arithmetic on 64-bit integers.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] d, output logic bo,
                                  output logic z, output logic ng, output logic ov);
        longint sa, sb, sd;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sd = sa - sb;
        d  = a - b;
        bo = (longint'({32'd0, a}) < longint'({32'd0, b}));
`ifdef SUB_FLAGS_EN
        z  = (d == 0);
        ng = (sd < 0) ? (sd >= -64'sd2147483648) : (sd > 64'sd2147483647);
        ov = (sd < -64'sd2147483648) || (sd > 64'sd2147483647);
`else
        z  = 1'b0;
        ng = 1'b0;
        ov = 1'b0;
`endif
    endfunction

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int hold, input bit poke);
        logic [N-1:0] d;
        logic bo, z, ng, ov;
        int lat;
        model(a, b, d, bo, z, ng, ov);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        input1   = a;
        input2   = b;
        @(negedge clk);
        lat      = 1;
        in_valid = 1'b0;
        input1   = $urandom;
        input2   = $urandom;
        while (!out_valid && lat < 4*K + 8) begin
            if (poke) in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, K + 1);
        check("answer", answer, d);
        check("borrow_out", borrow_out, bo);
        check("zero", zero, z);
        check("negative", negative, ng);
        check("overflow", overflow, ov);
        check("in_ready_done", in_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                input1   = $urandom;
                input2   = $urandom;
            end
            @(negedge clk);
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_answer", answer, d);
            check("hold_flags", {borrow_out, zero, negative, overflow}, {bo, z, ng, ov});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 1'b0);
        check("post_in_ready", in_ready, 1'b1);
        check("post_answer", answer, d);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        input1    = '0;
        input2    = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_answer", answer, 32'd0);
        check("rst_flags", {borrow_out, zero, negative, overflow}, 4'b0000);
        rst = 1'b0;

        run_op(32'd5, 32'd3, 0, 0);
        run_op(32'd0, 32'd1, 0, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 0, 0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(32'h1234_ABCD, 32'h1234_ABCD, 0, 0);
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 6, 1);

        // Reset during the second BUSY cycle discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        input1   = 32'hFFFF_FF77;
        input2   = 32'h0000_0011;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_answer", answer, 32'd0);
        for (int i = 0; i < K + 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_result", out_valid, 1'b0);
        end
        run_op(32'd100, 32'd58, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = '0;
                2: b = '1;
                default: ;
            endcase
            run_op(a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
